// File: rtl/rot_cmd_queue.sv
// Command FIFO plus registered result stage around an external 8-bit combinational barrel rotator.
// Commands queue up, the head drives the rotator, and its output is captured with a valid/ready handshake.
module rot_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [7:0]               cmd_data,
   input  logic [2:0]               cmd_shift,
   input  logic                     cmd_dir,
   output logic [7:0]               sh_in,
   output logic [2:0]               sh_shift,
   output logic                     sh_dir,
   input  logic [7:0]               sh_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         done_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] shift;
      logic       dir;
   } cmd_t;

   cmd_t             mem_q [DEPTH];
   cmd_t             mem_d [DEPTH];
   logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             res_valid_q, res_valid_d;
   logic [7:0]       res_data_q, res_data_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             load;
   logic             handoff;
   cmd_t             head;

   // Pointers carry one extra MSB so equal low bits with different MSBs means full.
   assign level     = wr_ptr_q - rd_ptr_q;
   assign full      = (level == LVL_W'(DEPTH));
   assign empty     = (level == '0);
   assign cmd_ready = !full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign handoff   = res_valid_q && res_ready;
   assign load      = !empty && (!res_valid_q || res_ready);

   assign head      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign sh_in     = head.data;
   assign sh_shift  = head.shift;
   assign sh_dir    = head.dir;

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign done_cnt  = done_cnt_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = '{data: cmd_data, shift: cmd_shift, dir: cmd_dir};
         wr_ptr_d = wr_ptr_q + LVL_W'(1);
      end
      if (load) begin
         rd_ptr_d = rd_ptr_q + LVL_W'(1);
      end
   end

   // A load refills the result register even while the old result is being taken.
   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      done_cnt_d  = done_cnt_q;
      if (load) begin
         res_valid_d = 1'b1;
         res_data_d  = sh_out;
      end else if (handoff) begin
         res_valid_d = 1'b0;
      end
      if (handoff) begin
         done_cnt_d = done_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         done_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   // Storage needs no reset: empty pointers mask it from every output.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_rot_cmd_queue.sv
// Self-checking bench for rot_cmd_queue: directed corners plus random traffic against
// a queue-based reference model; the external rotator is modelled bit by bit here.
module tb_rot_cmd_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_data;
   logic [2:0]       cmd_shift;
   logic             cmd_dir;
   logic [7:0]       sh_in;
   logic [2:0]       sh_shift;
   logic             sh_dir;
   logic [7:0]       sh_out;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_data;
   logic [2:0]       level;
   logic [CNT_W-1:0] done_cnt;

   int errorCount = 0;
   int checkCount = 0;

   // reference model state
   logic [11:0] cmdQ[$];
   logic        held;
   logic [7:0]  heldData;
   int          doneModel;
   int          pushCount;

   rot_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_shift (cmd_shift),
      .cmd_dir   (cmd_dir),
      .sh_in     (sh_in),
      .sh_shift  (sh_shift),
      .sh_dir    (sh_dir),
      .sh_out    (sh_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .level     (level),
      .done_cnt  (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External rotator: each input bit moves to its rotated position.
   always_comb begin
      sh_out = '0;
      for (int i = 0; i < 8; i++) begin
         if (!sh_dir) sh_out[(i + int'(sh_shift)) % 8] = sh_in[i];
         else         sh_out[(i + 8 - int'(sh_shift)) % 8] = sh_in[i];
      end
   end

   // Arithmetic rotation used by the reference model.
   function automatic logic [7:0] rotRef(input logic [7:0] d, input logic [2:0] s, input logic dir);
      int x;
      int n;
      int r;
      x = int'(d);
      n = int'(s);
      if (!dir) r = ((x << n) | (x >> (8 - n))) & 255;
      else      r = ((x >> n) | (x << (8 - n))) & 255;
      return 8'(r);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkModel();
      logic [11:0] headExp;
      headExp = (cmdQ.size() != 0) ? cmdQ[0] : 12'h000;
      checkOutput("res_valid", 32'(res_valid), 32'(held));
      checkOutput("res_data", 32'(res_data), 32'(heldData));
      checkOutput("level", 32'(level), 32'(cmdQ.size()));
      checkOutput("done_cnt", 32'(done_cnt), 32'(doneModel));
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(cmdQ.size() < DEPTH));
      checkOutput("sh_head", 32'({sh_in, sh_shift, sh_dir}), 32'(headExp));
   endtask

   // One clock cycle: drive inputs, advance the model across the edge, then compare.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] s,
                                input logic dr, input logic rr);
      logic        accept;
      logic        handoff;
      logic        load;
      logic [11:0] c;
      cmd_valid = v;
      cmd_data  = d;
      cmd_shift = s;
      cmd_dir   = dr;
      res_ready = rr;
      accept  = v && (cmdQ.size() < DEPTH);
      handoff = held && rr;
      load    = (cmdQ.size() != 0) && (!held || rr);
      @(posedge clk);
      if (handoff) doneModel = (doneModel + 1) % (1 << CNT_W);
      if (load) begin
         c        = cmdQ.pop_front();
         heldData = rotRef(c[11:4], c[3:1], c[0]);
         held     = 1'b1;
      end else if (handoff) begin
         held = 1'b0;
      end
      if (accept) begin
         cmdQ.push_back({d, s, dr});
         pushCount++;
      end
      #1;
      checkModel();
   endtask

   task automatic doReset(input int cycles);
      rst       = 1'b1;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      checkOutput("ready_in_rst", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      cmdQ.delete();
      held      = 1'b0;
      heldData  = 8'h00;
      doneModel = 0;
      pushCount = 0;
      #1;
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_res_data", 32'(res_data), 32'h00);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_sh", 32'({sh_in, sh_shift, sh_dir}), 32'd0);
   endtask

   task automatic directed(input string tag, input logic [7:0] d, input logic [2:0] s,
                           input logic dr, input logic [7:0] expected);
      applyStimulus(1'b1, d, s, dr, 1'b1);
      checkOutput({tag, "_not_bypassed"}, 32'(res_valid), 32'd0);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput(tag, 32'({res_valid, res_data}), 32'({1'b1, expected}));
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
   endtask

   initial begin
      int          accepts;
      logic [7:0]  firstExp;
      logic [7:0]  rd;
      logic [2:0]  rs;
      logic        rdir;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_shift = 3'd0;
      cmd_dir   = 1'b0;
      res_ready = 1'b0;
      held      = 1'b0;
      heldData  = 8'h00;
      doneModel = 0;
      pushCount = 0;

      $display("[TB] reset");
      doReset(2);

      $display("[TB] directed single commands");
      directed("rot81_l1", 8'h81, 3'd1, 1'b0, 8'h03);
      directed("rot81_r1", 8'h81, 3'd1, 1'b1, 8'hC0);
      directed("rot96_l3", 8'h96, 3'd3, 1'b0, 8'hB4);
      directed("rotA5_l4", 8'hA5, 3'd4, 1'b0, 8'h5A);
      directed("rotA5_r4", 8'hA5, 3'd4, 1'b1, 8'h5A);
      directed("rot3C_0",  8'h3C, 3'd0, 1'b0, 8'h3C);

      $display("[TB] fill under backpressure");
      doReset(1);
      accepts  = 0;
      firstExp = 8'h00;
      for (int i = 0; i < 8; i++) begin
         rd   = 8'($urandom);
         rs   = 3'($urandom);
         rdir = 1'($urandom);
         if (i == 0) firstExp = rotRef(rd, rs, rdir);
         if (cmd_ready) accepts++;
         applyStimulus(1'b1, rd, rs, rdir, 1'b0);
      end
      checkOutput("fill_accepts", 32'(accepts), 32'd5);
      checkOutput("fill_ready", 32'(cmd_ready), 32'd0);
      checkOutput("fill_level", 32'(level), 32'd4);
      checkOutput("fill_first", 32'({res_valid, res_data}), 32'({1'b1, firstExp}));

      $display("[TB] drain");
      for (int i = 0; i < 5; i++) begin
         checkOutput("drain_valid", 32'(res_valid), 32'd1);
         applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      end
      checkOutput("drain_level", 32'(level), 32'd0);
      checkOutput("drain_done", 32'(done_cnt), 32'd5);
      checkOutput("drain_valid_low", 32'(res_valid), 32'd0);

      $display("[TB] reset mid-operation");
      doReset(1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      end
      checkOutput("mid_level", 32'(level), 32'd3);
      checkOutput("mid_valid", 32'(res_valid), 32'd1);
      doReset(1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
         checkOutput("no_stale", 32'(res_valid), 32'd0);
      end

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 4) != 0, 8'($urandom), 3'($urandom), 1'($urandom),
                       ($urandom % 3) != 0);
      end

      $display("[TB] counter wrap");
      doReset(1);
      for (int i = 0; i < 600 && pushCount < 257; i++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b1);
      end
      checkOutput("wrap_pushes", 32'(pushCount), 32'd257);
      repeat (4) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput("wrap_done", 32'(done_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/rot_cmd_queue.md
# rot_cmd_queue

Command queue and result stage wrapped around the 8-bit combinational barrel rotator. It accepts rotate commands (data, amount, direction) over a valid/ready handshake and buffers them in a small FIFO. It presents the head command to the rotator's input ports, then captures the rotator output into a result register with its own valid/ready handshake. It gives the rotator a clocked, back-pressured front and back end, so it can sit in a pipelined datapath.

## Interface
- DEPTH, 4, command FIFO entries; power of two, at least 2
- CNT_W, 8, width of the completed-operation counter
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept a command
- cmd_data  in  8  operand
- cmd_shift  in  3  rotate amount, 0..7
- cmd_dir  in  1  0 = rotate left, 1 = rotate right
- sh_in  out  8  to rotator data input
- sh_shift  out  3  to rotator amount input
- sh_dir  out  1  to rotator direction input
- sh_out  in  8  from rotator output; combinational function of sh_*
- res_valid  out  1  result present
- res_ready  in  1  consumer takes result
- res_data  out  8  rotated result
- level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- done_cnt  out  CNT_W  results handed off since reset

## Operation
- **Push:** a command is written at the FIFO tail on any edge with cmd_valid && cmd_ready.
- **cmd_ready:** equals !full && !rst. It is 0 when level == DEPTH, even if a pop occurs in the same cycle; there is no push-through-full.
- **Rotator drive:** sh_in, sh_shift and sh_dir always show the FIFO head entry. When the FIFO is empty they are driven to 0.
- **Load condition:** load = !empty && (!res_valid || res_ready).
  - On a load edge: res_data <= sh_out, res_valid <= 1, and the head is popped.
  - When res_valid && res_ready && empty: res_valid <= 0 and res_data holds its value.
- **Simultaneous push and pop:** allowed when not full. level is unchanged and pointers advance independently.
- **Pointers:** wrap modulo DEPTH. level is computed from the pointer difference plus an extra MSB, so full and empty are distinguishable.
- **Ordering:** results leave in strict command order, with no reordering and no drops.
- **done_cnt:** increments on every edge with res_valid && res_ready. It wraps from 2^CNT_W−1 to 0.
- **Arithmetic:** rotation is modulo 8, so shift 0 passes the operand unchanged. Direction is passed through untouched; the block itself does no arithmetic on the data.
- **Empty path:** a command pushed into an empty FIFO is not bypassed. It must be written first, then loaded on the following edge.

## Timing
- **Reset (edge with rst = 1):** clears both pointers, level = 0, res_valid = 0, res_data = 0x00, done_cnt = 0, sh_* = 0. cmd_ready is 0 while rst is high and 1 in the first cycle after.
- **Reset mid-operation:** all queued commands and any held result are discarded. No res_valid may appear for pre-reset commands.
- **Latency:** a command accepted at edge N, into an empty queue with a free or draining result register, gives res_valid = 1 with its data after edge N+1.
- **Throughput:** one command per cycle sustained when res_ready stays high.
- **Backpressure:** with res_ready low, res_data and res_valid hold stable. Capacity is DEPTH queued commands plus 1 held result.
- **Handshake rule:** res_valid, once high, stays high until res_ready is sampled high. res_data does not change while res_valid && !res_ready.
- **Combinational path:** the only combinational path through the block is FIFO head → sh_* → external rotator → sh_out → res_data register input.

## Test plan
- **Reset:** pulse rst for 2 cycles → res_valid = 0, res_data = 0x00, level = 0, done_cnt = 0, and cmd_ready = 1 on the first cycle after rst falls.
- **Single commands (res_ready = 1):**
  - push 0x81, shift 1, dir 0 → res_data = 0x03 with res_valid one cycle after accept.
  - push 0x81, shift 1, dir 1 → 0xC0.
  - push 0x96, shift 3, dir 0 → 0xB4.
- **Amount corners:** push 0xA5, shift 4, dir 0 and dir 1 → 0x5A both times. Push 0x3C, shift 0 → 0x3C.
- **Fill (res_ready = 0, DEPTH = 4):** push continuously → exactly 5 commands accepted (1 held result + 4 queued). Then cmd_ready = 0, level = 4, and res_data stays at the first result.
- **Drain:** after the fill, raise res_ready → 5 results in push order on consecutive cycles, level reaches 0, done_cnt = 5, and res_valid drops after the last one.
- **Reset mid-operation and counter wrap:**
  - with level = 3 and res_valid = 1, assert rst for one cycle → everything cleared and no stale results afterward.
  - separately, 257 completed results → done_cnt = 1.
